uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_if.sv | 24 ++
 rtl/uart_rx_sampler.sv | 42 ++++
 rtl/uart_rx.sv | 162 ++++++++++++++++
 tb/tb_uart_rx.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART receive and transmit sides:
// line-state FSM encoding, default frame geometry and the 2-of-3 vote helper.
package uart_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_OVERSAMPLE = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if -- serial line, parity configuration and received-word result
// signals of the UART receiver. The line side drives through master, the
// receiver attaches through slave.
interface uart_rx_if #(
    parameter int DATA_WIDTH = uart_pkg::DEFAULT_DATA_WIDTH
);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP,
        input  P_DATA, data_valid, par_err, stp_err
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP,
        output P_DATA, data_valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler -- takes three samples around the bit centre (edge counts
// OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1) and registers their 2-of-3
// majority. bit_tick is high for the single cycle in which bit_val is new.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int CW         = $clog2(OVERSAMPLE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx,
    input  logic [CW-1:0] edge_cnt,
    output logic          bit_val,
    output logic          bit_tick
);
    localparam logic [CW-1:0] S0_EDGE = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] S1_EDGE = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] S2_EDGE = CW'(OVERSAMPLE / 2 + 1);

    logic s0;
    logic s1;

    // Hold the first two samples; the third is voted in directly as it arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0       <= 1'b0;
            s1       <= 1'b0;
            bit_val  <= 1'b0;
            bit_tick <= 1'b0;
        end else begin
            bit_tick <= 1'b0;
            if (edge_cnt == S0_EDGE) s0 <= rx;
            if (edge_cnt == S1_EDGE) s1 <= rx;
            if (edge_cnt == S2_EDGE) begin
                bit_val  <= majority3(s0, s1, rx);
                bit_tick <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- oversampling UART receiver, LSB first, one stop bit.
// Build option UART_RX_PARITY_EN: when defined, an optional parity bit
// (enabled per frame by PAR_EN, even/odd by PAR_TYP) is received and checked;
// when undefined PAR_EN/PAR_TYP are ignored and par_err stays 0.
// Results pulse one cycle after the stop-bit decision, which lands in the
// second half of the stop bit so the next start bit can follow without a gap.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input logic      clk,
    input logic      rst,
    uart_rx_if.slave bus
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] EDGE_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    uart_state_e           state;
    uart_state_e           state_next;
    logic [CW-1:0]         edge_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] p_data;
    logic                  bit_val;
    logic                  bit_tick;
    logic                  par_bad;
    logic                  dv_set;
    logic                  pe_set;
    logic                  se_set;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  rx;
    logic                  edge_last;
    logic                  bit_last;

    assign rx        = bus.RX_IN;
    assign edge_last = (edge_cnt == EDGE_LAST);
    assign bit_last  = (bit_cnt == BIT_LAST);

    assign bus.P_DATA     = p_data;
    assign bus.data_valid = data_valid;
    assign bus.par_err    = par_err;
    assign bus.stp_err    = stp_err;

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE),
        .CW         (CW)
    ) u_sampler (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .edge_cnt (edge_cnt),
        .bit_val  (bit_val),
        .bit_tick (bit_tick)
    );

`ifdef UART_RX_PARITY_EN
    logic par_en_l;
    logic par_typ_l;

    // Freeze the parity configuration at start detection and judge the parity bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_en_l  <= 1'b0;
            par_typ_l <= 1'b0;
            par_bad   <= 1'b0;
        end else begin
            if (state == IDLE) begin
                par_bad <= 1'b0;
                if (!rx) begin
                    par_en_l  <= bus.PAR_EN;
                    par_typ_l <= bus.PAR_TYP;
                end
            end else if (state == PARITY && bit_tick) begin
                par_bad <= bit_val ^ (^shift_reg) ^ par_typ_l;
            end
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = bus.PAR_EN ^ bus.PAR_TYP;
    assign par_bad    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state: bit boundaries come from the edge counter, early exits from the voted bit.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (!rx) state_next = START;
            START: begin
                if (bit_tick && bit_val) state_next = IDLE;
                else if (edge_last)      state_next = DATA;
            end
            DATA: begin
                if (edge_last && bit_last) begin
`ifdef UART_RX_PARITY_EN
                    state_next = par_en_l ? PARITY : STOP;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (edge_last) state_next = STOP;
`endif
            STOP:   if (bit_tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Result pulses are decided once, on the stop-bit decision.
    always_comb begin
        dv_set = 1'b0;
        pe_set = 1'b0;
        se_set = 1'b0;
        if (state == STOP && bit_tick) begin
            se_set = !bit_val;
            pe_set = par_bad;
            dv_set = bit_val && !par_bad;
        end
    end

    // Counters, shift register and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            p_data     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= dv_set;
            par_err    <= pe_set;
            stp_err    <= se_set;
            if (dv_set) p_data <= shift_reg;

            // The start edge itself counts as edge 0, so IDLE->START loads 1.
            if (state_next == IDLE || edge_last) edge_cnt <= '0;
            else                                 edge_cnt <= edge_cnt + 1'b1;

            if (state != DATA)  bit_cnt <= '0;
            else if (edge_last) bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;

            if (state == DATA && bit_tick)
                shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed frames for uart_rx (DATA_WIDTH=8, OVERSAMPLE=8).
// Each frame pushes its expected result (cycle, pulse flags, P_DATA) into a
// scoreboard; a monitor pops and compares whenever the receiver pulses.
`timescale 1ns/1ps
module tb_uart_rx;
    import uart_pkg::*;

    localparam int DW = 8;
    localparam int OS = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif

    typedef struct {
        int            cycle;
        logic          dv;
        logic          pe;
        logic          se;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    logic [DW-1:0] exp_pdata = '0;

    uart_rx_if #(.DATA_WIDTH(DW)) bus();

    uart_rx #(
        .DATA_WIDTH (DW),
        .OVERSAMPLE (OS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame driver: bits change on negedges; the next posedge is frame cycle 0.
    task automatic send_bit(input logic b);
        bus.RX_IN = b;
        repeat (OS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic par_en, input logic par_typ,
                              input logic par_bit, input logic stop_bit, input logic flip_cfg);
        exp_t e;
        logic rx_par;
        int   fb;
        rx_par  = PAR_BUILD && par_en;
        fb      = DW + 2 + (rx_par ? 1 : 0);
        e.cycle = cyc + 1 + (fb - 1) * OS + OS / 2 + 2;
        e.pe    = rx_par && (par_bit !== ((^d) ^ par_typ));
        e.se    = !stop_bit;
        e.dv    = stop_bit && !e.pe;
        if (e.dv) exp_pdata = d;
        e.data  = exp_pdata;
        sb.push_back(e);

        bus.PAR_EN  = par_en;
        bus.PAR_TYP = par_typ;
        bus.RX_IN   = 1'b0;
        @(negedge clk);
        if (flip_cfg) begin
            bus.PAR_EN  = ~par_en;
            bus.PAR_TYP = ~par_typ;
        end
        repeat (OS - 1) @(negedge clk);
        for (int i = 0; i < DW; i++) send_bit(d[i]);
        if (rx_par) send_bit(par_bit);
        send_bit(stop_bit);
        bus.RX_IN = 1'b1;
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.data_valid || bus.par_err || bus.stp_err) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {29'b0, bus.data_valid, bus.par_err, bus.stp_err}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("pulse_cycle", cyc, e.cycle);
                    check("data_valid", bus.data_valid, e.dv);
                    check("par_err", bus.par_err, e.pe);
                    check("stp_err", bus.stp_err, e.se);
                    check("p_data", bus.P_DATA, e.data);
                end
            end else if (sb.size() != 0 && cyc > sb[0].cycle) begin
                e = sb.pop_front();
                check("missed_pulse_at_cycle", cyc, e.cycle);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        logic          pen;
        logic          ptyp;

        bus.RX_IN   = 1'b1;
        bus.PAR_EN  = 1'b0;
        bus.PAR_TYP = 1'b0;
        rst         = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_p_data", bus.P_DATA, 32'h0);
        check("reset_data_valid", bus.data_valid, 32'h0);
        check("reset_par_err", bus.par_err, 32'h0);
        check("reset_stp_err", bus.stp_err, 32'h0);
        rst = 1'b0;
        repeat (2 * OS) @(negedge clk);

        // Good even-parity frame; configuration toggled right after start detection.
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (2 * OS) @(negedge clk);

        // Parity mismatch: no data_valid, P_DATA held.
        send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2 * OS) @(negedge clk);
        check("p_data_held", bus.P_DATA, exp_pdata);

        // Stop bit low, no parity.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2 * OS) @(negedge clk);

        // Two-cycle low glitch must be rejected silently.
        bus.RX_IN = 1'b0;
        repeat (2) @(negedge clk);
        bus.RX_IN = 1'b1;
        repeat (3 * OS) @(negedge clk);
        check("p_data_after_glitch", bus.P_DATA, exp_pdata);

        // Back-to-back frames with no idle gap.
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2 * OS) @(negedge clk);

        // Parity and stop faults together.
        send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3 * OS) @(negedge clk);

        // Good odd-parity frame.
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (2 * OS) @(negedge clk);

        // Random frames with correct parity.
        for (int i = 0; i < 4; i++) begin
            d    = DW'($urandom);
            pen  = 1'($urandom_range(0, 1));
            ptyp = 1'($urandom_range(0, 1));
            send_frame(d, pen, ptyp, (^d) ^ ptyp, 1'b1, 1'b0);
            repeat (OS) @(negedge clk);
        end
        send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2 * OS) @(negedge clk);
        check("p_data_before_reset", bus.P_DATA, exp_pdata);

        // Reset 40 cycles into a 0x5A frame, then receive 0x5A cleanly.
        d = 8'h5A;
        bus.PAR_EN = 1'b0;
        bus.RX_IN  = 1'b0;
        repeat (OS) @(negedge clk);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        #2;
        rst = 1'b1;
        #1;
        exp_pdata = '0;
        check("midframe_reset_p_data", bus.P_DATA, 32'h0);
        check("midframe_reset_data_valid", bus.data_valid, 32'h0);
        check("midframe_reset_par_err", bus.par_err, 32'h0);
        check("midframe_reset_stp_err", bus.stp_err, 32'h0);
        @(negedge clk);
        bus.RX_IN = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2 * OS) @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2 * OS) @(negedge clk);

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
